// File: rtl/fp_mult_unpack_if.sv
// Operand/result handshake bundle between the FP32 multiplier front end and its neighbours.
// slave = the unpack stage, master = the producer/consumer driving it.
interface fp_mult_unpack_if;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [22:0] NormM;
  logic [8:0]  NormE;
  logic        Sp;
  logic        GRS;
  logic [4:0]  InputExc;

  modport slave (
    input  a, b, in_valid, out_ready,
    output in_ready, out_valid, NormM, NormE, Sp, GRS, InputExc
  );

  modport master (
    output a, b, in_valid, out_ready,
    input  in_ready, out_valid, NormM, NormE, Sp, GRS, InputExc
  );
endinterface

// File: rtl/fp_mult_unpack.sv
// FP32 multiplier front end: unpack/classify + 24x24 product (stage 1),
// normalize, round-up decision and exception flags (stage 2).
module fp_mult_unpack #(
  parameter int BIAS = 127,
  parameter bit FTZ  = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  fp_mult_unpack_if.slave    bus
);

  // ---------------- handshake ----------------
  logic r_s1_v, r_s2_v;
  logic w_s1_load, w_s2_load;

  assign w_s2_load    = !r_s2_v || bus.out_ready;
  assign w_s1_load    = !r_s1_v || w_s2_load;
  assign bus.in_ready = w_s1_load;
  assign bus.out_valid = r_s2_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      if (w_s1_load) r_s1_v <= bus.in_valid;
      if (w_s2_load) r_s2_v <= r_s1_v;
    end
  end

  // ---------------- stage 1: unpack, classify, multiply ----------------
  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_fa, w_fb;
  logic [23:0] w_ma, w_mb;
  logic        w_nan_a, w_inf_a, w_zero_a, w_nan_b, w_inf_b, w_zero_b;

  assign w_ea = bus.a[30:23];
  assign w_eb = bus.b[30:23];
  assign w_fa = bus.a[22:0];
  assign w_fb = bus.b[22:0];

  // With FTZ a zero exponent kills the whole mantissa, so denormals multiply as zero.
  assign w_ma = (w_ea != 8'd0) ? {1'b1, w_fa} : (FTZ ? 24'd0 : {1'b0, w_fa});
  assign w_mb = (w_eb != 8'd0) ? {1'b1, w_fb} : (FTZ ? 24'd0 : {1'b0, w_fb});

  assign w_nan_a  = (&w_ea) && (|w_fa);
  assign w_inf_a  = (&w_ea) && !(|w_fa);
  assign w_zero_a = (w_ea == 8'd0) && (FTZ || (w_fa == 23'd0));
  assign w_nan_b  = (&w_eb) && (|w_fb);
  assign w_inf_b  = (&w_eb) && !(|w_fb);
  assign w_zero_b = (w_eb == 8'd0) && (FTZ || (w_fb == 23'd0));

  logic [47:0] r_p;
  logic [8:0]  r_sum;
  logic        r_sp1;
  logic [5:0]  r_cls;   // {nan_a, inf_a, zero_a, nan_b, inf_b, zero_b}

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p   <= '0;
      r_sum <= '0;
      r_sp1 <= 1'b0;
      r_cls <= '0;
    end else if (w_s1_load && bus.in_valid) begin
      r_p   <= w_ma * w_mb;
      r_sum <= {1'b0, w_ea} + {1'b0, w_eb};
      r_sp1 <= bus.a[31] ^ bus.b[31];
      r_cls <= {w_nan_a, w_inf_a, w_zero_a, w_nan_b, w_inf_b, w_zero_b};
    end
  end

  // ---------------- stage 2: normalize, round decision, flags ----------------
  logic        w_hi, w_g, w_s, w_grs;
  logic [22:0] w_nm;
  logic [8:0]  w_ne;
  logic        w_inv, w_inf, w_zero, w_spec, w_ovf, w_unf;

  assign w_hi  = r_p[47];
  assign w_nm  = w_hi ? r_p[46:24] : r_p[45:23];
  assign w_g   = w_hi ? r_p[23]    : r_p[22];
  assign w_s   = w_hi ? (|r_p[22:0]) : (|r_p[21:0]);
  assign w_ne  = r_sum + {8'd0, w_hi};
  assign w_grs = w_g && (w_s || w_nm[0]);

  assign w_inv  = r_cls[5] || r_cls[2] || (r_cls[4] && r_cls[0]) || (r_cls[3] && r_cls[1]);
  assign w_inf  = (r_cls[4] || r_cls[1]) && !w_inv;
  assign w_zero = (r_cls[3] || r_cls[0]) && !w_inv && !w_inf;
  assign w_spec = w_inv || w_inf || w_zero;
  assign w_ovf  = !w_spec && (w_ne >= 9'(BIAS + 255));
  assign w_unf  = !w_spec && (w_ne <= 9'(BIAS));

  logic [22:0] r_normm;
  logic [8:0]  r_norme;
  logic        r_sp, r_grs;
  logic [4:0]  r_exc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_normm <= '0;
      r_norme <= '0;
      r_sp    <= 1'b0;
      r_grs   <= 1'b0;
      r_exc   <= '0;
    end else if (w_s2_load && r_s1_v) begin
      r_normm <= w_nm;
      r_norme <= w_ne;
      r_sp    <= r_sp1;
      r_grs   <= w_grs;
      r_exc   <= {w_inv, w_inf, w_zero, w_ovf, w_unf};
    end
  end

  assign bus.NormM    = r_normm;
  assign bus.NormE    = r_norme;
  assign bus.Sp       = r_sp;
  assign bus.GRS      = r_grs;
  assign bus.InputExc = r_exc;

endmodule
